ysyx_22040895_pcu: RTL
======================

Name: ysyx_22040895_pcu

Overview:
Program-counter sequencer for the multi-cycle single-issue core. Owns the architectural PC and issues one fetch request per instruction to the IFU. It hands the fetched instruction to the IDU, then waits for the EXU/branch-compare result. It then selects the next PC in priority order: trap, mret, taken branch/jump, sequential. It is the sole consumer of the branch unit's taken flag and target.

Parameters:
XLEN, 64, width of PC and all address/data buses
RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset
INST_W, 32, instruction width

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-high reset
ifu_req_valid_o  output  1  fetch request valid
ifu_req_ready_i  input  1  IFU accepts request
ifu_req_addr_o  output  XLEN  fetch address (= current PC)
ifu_rsp_valid_i  input  1  fetch response valid (one-cycle pulse)
ifu_rsp_inst_i  input  INST_W  fetched instruction
ifu_rsp_err_i  input  1  access fault, qualified by rsp_valid
idu_inst_valid_o  output  1  instruction valid to IDU
idu_inst_ready_i  input  1  IDU accepts instruction
idu_inst_o  output  INST_W  held instruction
idu_pc_o  output  XLEN  PC of held instruction
exu_done_i  input  1  current instruction resolved (pulse)
jump_branch_i  input  1  branch/jump taken, qualified by exu_done_i
dnpc_i  input  XLEN  taken target, qualified by exu_done_i
trap_i  input  1  exception/ecall, qualified by exu_done_i
mret_i  input  1  mret, qualified by exu_done_i
mtvec_i  input  XLEN  trap vector
mepc_i  input  XLEN  return address
fault_o  output  1  one-cycle pulse: fetch fault or misaligned target taken
fault_cause_o  output  2  00 none, 01 fetch access fault, 10 target misaligned

Behaviour:
- Reset (async assert, sync release): state=IDLE, pc=RESET_PC, all valids 0, idu_inst_o=0, idu_pc_o=0, fault_o=0, fault_cause_o=0.
- FSM states and transitions:
  - IDLE: entered only from reset. Moves to FETCH on the first clock after reset release.
  - FETCH: ifu_req_valid_o=1, ifu_req_addr_o=pc. Valid and address are held stable until ready. Moves to WAIT_RSP on valid&ready.
  - WAIT_RSP: waits for ifu_rsp_valid_i.
    - Response with rsp_err=1: pc<=mtvec_i, fault_o pulses with cause 01, return to FETCH. No IDU issue.
    - Response with rsp_err=0: latch inst and pc, go to ISSUE.
  - ISSUE: idu_inst_valid_o=1 with inst and pc held stable. Moves to EXEC on valid&ready.
  - EXEC: waits for exu_done_i. Next PC priority: trap_i → mtvec_i; else mret_i → mepc_i; else jump_branch_i → dnpc_i; else pc+4 (modulo 2^XLEN, wraps silently). Then back to FETCH.
- Misaligned target: if the selected next PC is dnpc_i with bits[1:0] != 0, pc<=mtvec_i instead and fault_o pulses with cause 10. mtvec_i/mepc_i are used unchecked.
- Simultaneous trap_i and mret_i: trap wins. jump_branch_i is ignored when trap_i or mret_i is set.
- Inputs outside their qualifying state are ignored: exu_done_i outside EXEC, ifu_rsp_valid_i outside WAIT_RSP.
- Latency: minimum 4 cycles per instruction (FETCH→WAIT_RSP→ISSUE→EXEC), with 0-wait IFU/IDU and done in the first EXEC cycle.
- Reset mid-operation: immediate return to reset values. A late IFU response after reset is dropped because the FSM is not in WAIT_RSP.
- fault_o is high for exactly one cycle per event and never asserts in other cycles.

Optional Feature:
YSYX_22040895_PCU_PERF_EN
- Defined: adds output ports perf_retired_o (XLEN), perf_taken_o (XLEN) and perf_fault_o (XLEN).
  - perf_retired_o increments on each exu_done_i in EXEC.
  - perf_taken_o increments when jump_branch_i is selected as the next-PC source.
  - perf_fault_o increments on each fault_o pulse.
  - All counters reset to 0 and wrap at 2^XLEN.
- Undefined: ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset release, IFU ready=1, rsp after 1 cycle, IDU ready=1, done without branch → fetch addresses 0x8000_0000, 0x8000_0004, 0x8000_0008; 4 cycles per instruction.
- In EXEC at pc=0x8000_0010: done with jump_branch=1, dnpc=0x8000_0100 → next ifu_req_addr_o=0x8000_0100.
- done with trap=1, mret=1, jump_branch=1, mtvec=0x8000_0400 → next fetch 0x8000_0400, fault_o stays 0.
- jump_branch=1, dnpc=0x8000_0102, mtvec=0x8000_0400 → fault_o pulses one cycle with cause 10; next fetch 0x8000_0400.
- ifu_req_ready_i held low 5 cycles, then rsp with err=1 → req valid and address stable throughout; no idu_inst_valid_o; fault cause 01; next fetch mtvec.
- Assert rst while in ISSUE → outputs immediately return to reset values. A stray rsp_valid in the next cycle is ignored, and the first fetch is 0x8000_0000.

Source files
------------

// File: rtl/ysyx_22040895_pcu.sv
// +--------------------------------------------------------------------------+
// | ysyx_22040895_pcu : program-counter sequencer (fetch/issue/exec loop).   |
// | Optional perf counters: define YSYX_22040895_PCU_PERF_EN.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module ysyx_22040895_pcu #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h0000_0000_8000_0000),
  parameter int              INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ifu_req_valid_o,
  input  logic              ifu_req_ready_i,
  output logic [XLEN-1:0]   ifu_req_addr_o,
  input  logic              ifu_rsp_valid_i,
  input  logic [INST_W-1:0] ifu_rsp_inst_i,
  input  logic              ifu_rsp_err_i,
  output logic              idu_inst_valid_o,
  input  logic              idu_inst_ready_i,
  output logic [INST_W-1:0] idu_inst_o,
  output logic [XLEN-1:0]   idu_pc_o,
  input  logic              exu_done_i,
  input  logic              jump_branch_i,
  input  logic [XLEN-1:0]   dnpc_i,
  input  logic              trap_i,
  input  logic              mret_i,
  input  logic [XLEN-1:0]   mtvec_i,
  input  logic [XLEN-1:0]   mepc_i,
`ifdef YSYX_22040895_PCU_PERF_EN
  output logic [XLEN-1:0]   perf_retired_o,
  output logic [XLEN-1:0]   perf_taken_o,
  output logic [XLEN-1:0]   perf_fault_o,
`endif
  output logic              fault_o,
  output logic [1:0]        fault_cause_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_RSP = 3'd2,
    S_ISSUE    = 3'd3,
    S_EXEC     = 3'd4
  } state_t;

  localparam logic [1:0] c_CAUSE_NONE  = 2'b00;
  localparam logic [1:0] c_CAUSE_FETCH = 2'b01;
  localparam logic [1:0] c_CAUSE_ALIGN = 2'b10;

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic              r_req_valid;
  logic              r_idu_valid;
  logic [INST_W-1:0] r_inst;
  logic [XLEN-1:0]   r_idu_pc;
  logic              r_fault;
  logic [1:0]        r_fault_cause;

  logic              w_sel_branch;
  logic              w_misaligned;
  logic [XLEN-1:0]   w_next_pc;

  // Branch target only counts when no trap/mret overrides it.
  always_comb begin
    w_sel_branch = jump_branch_i && !trap_i && !mret_i;
    w_misaligned = w_sel_branch && (dnpc_i[1:0] != 2'b00);
    w_next_pc    = r_pc + XLEN'(4);
    if (trap_i)            w_next_pc = mtvec_i;
    else if (mret_i)       w_next_pc = mepc_i;
    else if (w_misaligned) w_next_pc = mtvec_i;
    else if (w_sel_branch) w_next_pc = dnpc_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_req_valid   <= 1'b0;
      r_idu_valid   <= 1'b0;
      r_inst        <= '0;
      r_idu_pc      <= '0;
      r_fault       <= 1'b0;
      r_fault_cause <= c_CAUSE_NONE;
    end else begin
      r_fault       <= 1'b0;
      r_fault_cause <= c_CAUSE_NONE;
      case (r_state)
        S_IDLE: begin
          r_state     <= S_FETCH;
          r_req_valid <= 1'b1;
        end
        S_FETCH: begin
          if (ifu_req_ready_i) begin
            r_req_valid <= 1'b0;
            r_state     <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          if (ifu_rsp_valid_i) begin
            if (ifu_rsp_err_i) begin
              r_pc          <= mtvec_i;
              r_fault       <= 1'b1;
              r_fault_cause <= c_CAUSE_FETCH;
              r_req_valid   <= 1'b1;
              r_state       <= S_FETCH;
            end else begin
              r_inst      <= ifu_rsp_inst_i;
              r_idu_pc    <= r_pc;
              r_idu_valid <= 1'b1;
              r_state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (idu_inst_ready_i) begin
            r_idu_valid <= 1'b0;
            r_state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (exu_done_i) begin
            r_pc        <= w_next_pc;
            r_req_valid <= 1'b1;
            r_state     <= S_FETCH;
            if (w_misaligned) begin
              r_fault       <= 1'b1;
              r_fault_cause <= c_CAUSE_ALIGN;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_valid <= 1'b0;
          r_idu_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef YSYX_22040895_PCU_PERF_EN
  logic [XLEN-1:0] r_perf_retired;
  logic [XLEN-1:0] r_perf_taken;
  logic [XLEN-1:0] r_perf_fault;
  logic            w_exec_done;
  logic            w_fetch_fault;

  assign w_exec_done   = (r_state == S_EXEC) && exu_done_i;
  assign w_fetch_fault = (r_state == S_WAIT_RSP) && ifu_rsp_valid_i && ifu_rsp_err_i;

  // Counters advance on the same edge that raises the corresponding fault pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_retired <= '0;
      r_perf_taken   <= '0;
      r_perf_fault   <= '0;
    end else begin
      if (w_exec_done)
        r_perf_retired <= r_perf_retired + XLEN'(1);
      if (w_exec_done && w_sel_branch && !w_misaligned)
        r_perf_taken <= r_perf_taken + XLEN'(1);
      if (w_fetch_fault || (w_exec_done && w_misaligned))
        r_perf_fault <= r_perf_fault + XLEN'(1);
    end
  end

  assign perf_retired_o = r_perf_retired;
  assign perf_taken_o   = r_perf_taken;
  assign perf_fault_o   = r_perf_fault;
`endif

  assign ifu_req_valid_o  = r_req_valid;
  assign ifu_req_addr_o   = r_pc;
  assign idu_inst_valid_o = r_idu_valid;
  assign idu_inst_o       = r_inst;
  assign idu_pc_o         = r_idu_pc;
  assign fault_o          = r_fault;
  assign fault_cause_o    = r_fault_cause;

endmodule

`default_nettype wire
